// File: rtl/dual_port_ram.sv
// dual_port_ram: one-write / one-read synchronous RAM with a registered read
// port, a post-reset init sequencer and out-of-range access flagging.
// Optional feature macro: RAM_PARITY_EN. When it is defined, each word carries
// an even-parity bit and par_err reports a mismatch on read data.
module dual_port_ram #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 8,
  parameter int                 DEPTH    = 256,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inj_par_err,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              oob_err,
  output logic              par_err
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  // Addresses are compared one bit wider so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] init_cnt;
  logic [MEM_W-1:0]  mem [DEPTH];

  logic              run;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_go;
  logic              collide;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  init_word;
  logic [MEM_W-1:0]  rd_word;

`ifdef RAM_PARITY_EN
  // High when the stored parity bit disagrees with the data it covers.
  function automatic logic par_mismatch(input logic [MEM_W-1:0] w);
    return w[DATA_W] ^ (^w[DATA_W-1:0]);
  endfunction

  assign wr_word   = {(^wr_data) ^ inj_par_err, wr_data};
  assign init_word = {^INIT_VAL, INIT_VAL};
`else
  logic unused_inj;
  assign unused_inj = inj_par_err;
  assign wr_word    = wr_data;
  assign init_word  = INIT_VAL;
`endif

  assign run         = (state == ST_RUN);
  assign init_busy   = (state == ST_INIT);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
  assign wr_go       = run && wr_en && wr_in_range;
  // Write-first: a same-address write in the same cycle is forwarded to the read.
  assign collide     = wr_go && rd_en && (wr_addr == rd_addr);
  assign rd_word     = collide ? wr_word : mem[rd_addr];

  // Memory array: init sequencer fill, then normal in-range writes.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_cnt] <= init_word;
    end else if (wr_go) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Control state, init counter and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      oob_err  <= 1'b0;
    end else if (state == ST_INIT) begin
      rd_valid <= 1'b0;
      oob_err  <= 1'b0;
      if (init_cnt == LAST_ADDR) begin
        state <= ST_RUN;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end else begin
      rd_valid <= rd_en;
      oob_err  <= (wr_en && !wr_in_range) || (rd_en && !rd_in_range);
      if (rd_en) begin
        rd_data <= rd_in_range ? rd_word[DATA_W-1:0] : '0;
      end
    end
  end

`ifdef RAM_PARITY_EN
  // Parity check result, aligned with rd_data and only set alongside rd_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (run && rd_en && rd_in_range) begin
      par_err <= par_mismatch(rd_word);
    end else begin
      par_err <= 1'b0;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
